link_frame_scheduler: RTL

Sequences the outbound UART command frame of the simulated-device link and arbitrates the two one-shot barrier actions (place, destroy) onto it. Sits between the driving-mode logic (manual / semi-auto / auto `moving_state` mux) and `uart_top`. It builds the frame `{2'b10, destroy, place, moving[3:0]}`. Each barrier request is stretched to a fixed hold window and separated by a gap, so the device never sees both actions at once. The block also registers the detector nibble returned by the device.

---
 rtl/link_pkg.sv | 29 ++
 rtl/req_edge_latch.sv | 35 +++
 rtl/link_frame_scheduler.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/link_pkg.sv
// Shared types and constants for the outbound link frame scheduler.
package link_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [1:0] GNT_NONE    = 2'b00;
    localparam logic [1:0] GNT_PLACE   = 2'b01;
    localparam logic [1:0] GNT_DESTROY = 2'b10;

    localparam logic [1:0] FRAME_HDR = 2'b10;

    localparam int unsigned FRM_DESTROY_BIT = 5;
    localparam int unsigned FRM_PLACE_BIT   = 4;
    localparam int unsigned FRM_MOVE_MSB    = 3;

    localparam int unsigned DET_FRONT = 0;
    localparam int unsigned DET_LEFT  = 1;
    localparam int unsigned DET_RIGHT = 2;
    localparam int unsigned DET_BACK  = 3;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/req_edge_latch.sv
// Rising-edge detector feeding a sticky pending flag; cancel beats clear beats set.
module req_edge_latch (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_req,
    input  logic i_clr,
    input  logic i_cancel,
    output logic o_pending
);

    logic r_prev;
    logic r_pending;
    logic w_rise;

    assign w_rise = i_req & ~r_prev;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_prev    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_prev <= i_req;
            if (i_cancel) begin
                r_pending <= 1'b0;
            end else if (i_clr) begin
                r_pending <= 1'b0;
            end else if (w_rise) begin
                r_pending <= 1'b1;
            end
        end
    end

    assign o_pending = r_pending;

endmodule

// File: rtl/link_frame_scheduler.sv
// Builds the outbound UART frame and serialises place/destroy into hold+gap windows.
// Define LINK_ACTION_RR_EN for round-robin tie-breaking (default: destroy wins).
module link_frame_scheduler
    import link_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 10_000_000,
    parameter int unsigned GAP_CYCLES  = 5_000_000
) (
    input  logic       sys_clk,
    input  logic       rst,
    input  logic       power,
    input  logic [3:0] moving_state,
    input  logic       place_req,
    input  logic       destroy_req,
    input  logic [7:0] rec,
    output logic [7:0] frame,
    output logic [3:0] detector,
    output logic       busy,
    output logic [1:0] grant
);

    localparam int unsigned CNT_W = $clog2(max_u(HOLD_CYCLES, GAP_CYCLES) + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    state_t           r_state, w_state_d;
    logic [CNT_W-1:0] r_cnt, w_cnt_d;
    logic [1:0]       r_grant, w_grant_d;
    logic [1:0]       w_pick;
    logic [3:0]       r_mov;
    logic [3:0]       r_det;
    logic             w_place_pend, w_destroy_pend;
    logic             w_place_clr, w_destroy_clr;
    logic             w_in_hold;
    logic             w_unused_rec;

    assign w_unused_rec = ^rec[7:4];

    req_edge_latch u_place_latch (
        .i_clk     (sys_clk),
        .i_rst     (rst),
        .i_req     (place_req),
        .i_clr     (w_place_clr),
        .i_cancel  (~power),
        .o_pending (w_place_pend)
    );

    req_edge_latch u_destroy_latch (
        .i_clk     (sys_clk),
        .i_rst     (rst),
        .i_req     (destroy_req),
        .i_clr     (w_destroy_clr),
        .i_cancel  (~power),
        .o_pending (w_destroy_pend)
    );

`ifdef LINK_ACTION_RR_EN
    logic [1:0] r_last_grant;

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= GNT_DESTROY;
        end else if (r_state == IDLE && w_state_d == HOLD) begin
            r_last_grant <= w_grant_d;
        end
    end
`endif

    always_comb begin
        w_pick = GNT_NONE;
        if (w_place_pend && w_destroy_pend) begin
`ifdef LINK_ACTION_RR_EN
            w_pick = (r_last_grant == GNT_DESTROY) ? GNT_PLACE : GNT_DESTROY;
`else
            w_pick = GNT_DESTROY;
`endif
        end else if (w_destroy_pend) begin
            w_pick = GNT_DESTROY;
        end else if (w_place_pend) begin
            w_pick = GNT_PLACE;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_grant_d     = r_grant;
        w_place_clr   = 1'b0;
        w_destroy_clr = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_pick != GNT_NONE) begin
                    w_state_d = HOLD;
                    w_grant_d = w_pick;
                end
            end
            HOLD: begin
                if (r_cnt == HOLD_LAST) begin
                    w_state_d     = GAP;
                    w_grant_d     = GNT_NONE;
                    w_place_clr   = (r_grant == GNT_PLACE);
                    w_destroy_clr = (r_grant == GNT_DESTROY);
                end
            end
            GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_d = IDLE;
                end
            end
            default: begin
                w_state_d = IDLE;
                w_grant_d = GNT_NONE;
            end
        endcase
        if (!power) begin
            w_state_d = IDLE;
            w_grant_d = GNT_NONE;
        end
    end

    // Counter restarts on every state change and saturates rather than wrapping.
    always_comb begin
        if (w_state_d != r_state || w_state_d == IDLE) begin
            w_cnt_d = '0;
        end else if (r_cnt != '1) begin
            w_cnt_d = r_cnt + 1'b1;
        end else begin
            w_cnt_d = r_cnt;
        end
    end

    always_ff @(posedge sys_clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_grant <= GNT_NONE;
            r_mov   <= 4'd0;
            r_det   <= 4'd0;
        end else begin
            r_state <= w_state_d;
            r_cnt   <= w_cnt_d;
            r_grant <= w_grant_d;
            r_mov   <= power ? moving_state : 4'd0;
            r_det   <= rec[DET_BACK:DET_FRONT];
        end
    end

    // Action bits decode straight from registers so reset clears them without a clock.
    assign w_in_hold = (r_state == HOLD);
    assign frame     = {FRAME_HDR,
                        w_in_hold && (r_grant == GNT_DESTROY),
                        w_in_hold && (r_grant == GNT_PLACE),
                        r_mov};
    assign detector  = r_det;
    assign busy      = (r_state != IDLE);
    assign grant     = r_grant;

endmodule
